pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with redirect, halt, stall and
// one-cycle pipeline flush after every taken redirect.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned redirect
// targets. With the macro on, a redirect whose target has bits [1:0] != 00
// holds pc, enters HALTED and sets the sticky misalign flag. With the macro
// off, the low two target bits are cleared and misalign is tied to 0.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   branch[1:0]  11 branch/JAL target, 01 JALR target, 10 PC+4, 00 hold/halt
//   target_br    PC+offset target for branch/JAL
//   target_jalr  rs1+imm target for JALR (bit 0 is always cleared)
//   stall        hazard stall, holds pc while running sequentially
//   resume       restart request while halted
//   pc           current fetch address (registered)
//   pc_plus4     pc + 4 (combinational from pc)
//   flush        one-cycle squash of IF/ID and ID/EX, decoded from state
//   halted       high while in HALTED, decoded from state
//   misalign     sticky misaligned-target flag
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal fetch: redirect > halt > stall > sequential
// FLUSH  | redirect just taken; squash younger stages, advance pc by 4
// HALTED | pc frozen; only resume (or reset) leaves this state

module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  branch,
   input  logic [31:0] target_br,
   input  logic [31:0] target_jalr,
   input  logic        stall,
   input  logic        resume,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        flush,
   output logic        halted,
   output logic        misalign
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_FLUSH  = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_jalr;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;
   logic        w_redirect;
   logic        w_trap;

   // Both redirect encodings (11 and 01) have bit 0 set.
   assign w_redirect   = branch[0];
   assign w_jalr       = target_jalr & ~32'h0000_0001;
   assign w_target_raw = branch[1] ? target_br : w_jalr;
   assign w_pc_plus4   = r_pc + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
   logic r_misalign;
   logic w_misalign_set;

   assign w_target       = w_target_raw;
   assign w_trap         = w_redirect && (w_target_raw[1:0] != 2'b00);
   assign w_misalign_set = (r_state == ST_RUN) && w_trap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if (w_misalign_set) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign = r_misalign;
`else
   assign w_target = w_target_raw & ~32'h0000_0003;
   assign w_trap   = 1'b0;
   assign misalign = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         ST_RUN: begin
            if (w_redirect) begin
               if (w_trap) begin
                  w_state_nxt = ST_HALTED;
               end else begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = ST_FLUSH;
               end
            end else if (branch == 2'b00) begin
               w_state_nxt = ST_HALTED;
            end else if (!stall) begin
               w_pc_nxt = w_pc_plus4;
            end
         end
         ST_FLUSH: begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ST_RUN;
         end
         ST_HALTED: begin
            if (resume) begin
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Outputs depend on registered state only
   always_comb begin
      pc       = r_pc;
      pc_plus4 = w_pc_plus4;
      flush    = (r_state == ST_FLUSH);
      halted   = (r_state == ST_HALTED);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [1:0]  branch;
   logic [31:0] target_br;
   logic [31:0] target_jalr;
   logic        stall;
   logic        resume;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush;
   logic        halted;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .branch      (branch),
      .target_br   (target_br),
      .target_jalr (target_jalr),
      .stall       (stall),
      .resume      (resume),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .flush       (flush),
      .halted      (halted),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; branch = 2'b10; stall = 1'b0; resume = 1'b0;
      target_br = '0; target_jalr = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h4); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc [3];
      exp_pc = '{32'h4, 32'h8, 32'hC};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         branch = 2'b10; stall = 1'b0;
         tick();
         checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pc[i]); end
         checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush%0d got %b exp 0", i, flush); end
      end
   endtask

   task automatic test_branch();
      do_reset();
      branch = 2'b10; tick(); tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_setup got %h exp %h", pc, 32'h8); end
      branch = 2'b11; target_br = 32'h40;
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp %h", pc, 32'h40); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", flush); end
      tick();
      checks++; if (pc !== 32'h44) begin errors++; $display("FAIL br_flush_pc got %h exp %h", pc, 32'h44); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_drop got %b exp 0", flush); end
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'h48) begin errors++; $display("FAIL br_after got %h exp %h", pc, 32'h48); end
   endtask

   task automatic test_jalr();
      do_reset();
      branch = 2'b01; target_jalr = 32'h101;
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jalr_pc got %h exp %h", pc, 32'h100); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got %b exp 1", flush); end
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL jalr_next got %h exp %h", pc, 32'h104); end
`ifdef PC_MISALIGN_TRAP_EN
      branch = 2'b01; target_jalr = 32'h102;
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL trap_pc got %h exp %h", pc, 32'h104); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL trap_halted got %b exp 1", halted); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL trap_misalign got %b exp 1", misalign); end
      branch = 2'b10; resume = 1'b1;
      tick();
      resume = 1'b0;
      checks++; if (pc !== 32'h108) begin errors++; $display("FAIL trap_resume_pc got %h exp %h", pc, 32'h108); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL trap_sticky got %b exp 1", misalign); end
`else
      branch = 2'b11; target_br = 32'h203;
      tick();
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL br_mask_pc got %h exp %h", pc, 32'h200); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_mask_misalign got %b exp 0", misalign); end
      branch = 2'b01; target_jalr = 32'h307;
      tick();
      checks++; if (pc !== 32'h204) begin errors++; $display("FAIL jalr_in_flush got %h exp %h", pc, 32'h204); end
`endif
   endtask

   task automatic test_halt();
      do_reset();
      branch = 2'b11; target_br = 32'h1C;
      tick();
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL halt_setup got %h exp %h", pc, 32'h20); end
      branch = 2'b00;
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter got %b exp 1", halted); end
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL halt_pc got %h exp %h", pc, 32'h20); end
      branch = 2'b11; stall = 1'b1; target_br = 32'h80;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (pc !== 32'h20 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold%0d got pc %h halted %b exp 20 1", i, pc, halted); end
      end
      branch = 2'b10; stall = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0;
      checks++; if (pc !== 32'h24) begin errors++; $display("FAIL resume_pc got %h exp %h", pc, 32'h24); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got %b exp 0", halted); end
   endtask

   task automatic test_stall();
      do_reset();
      branch = 2'b11; target_br = 32'hC;
      tick();
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_setup got %h exp %h", pc, 32'h10); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, pc, 32'h10); end
      end
      branch = 2'b11; target_br = 32'h80;
      tick();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL stall_redirect got %h exp %h", pc, 32'h80); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_redirect_flush got %b exp 1", flush); end
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'h84) begin errors++; $display("FAIL stall_in_flush got %h exp %h", pc, 32'h84); end
      branch = 2'b00;
      tick();
      checks++; if (halted !== 1'b1 || pc !== 32'h84) begin errors++; $display("FAIL stall_vs_halt got halted %b pc %h exp 1 84", halted, pc); end
      stall = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      branch = 2'b11; target_br = 32'hFFFF_FFF8;
      tick();
      branch = 2'b10;
      tick();
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp %h", pc, 32'hFFFF_FFFC); end
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp %h", pc_plus4, 32'h0); end
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL wrap_misalign got %b exp 0", misalign); end
   endtask

   task automatic test_reset_abort();
      do_reset();
      branch = 2'b11; target_br = 32'h60;
      tick();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL abort_flush_setup got %b exp 1", flush); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (pc !== 32'h0 || flush !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL abort_flush got pc %h flush %b halted %b exp 0 0 0", pc, flush, halted); end
      branch = 2'b10;
      tick();
      branch = 2'b00;
      tick();
      checks++; if (halted !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL abort_halt_setup got halted %b pc %h exp 1 4", halted, pc); end
      rst = 1'b1; resume = 1'b1;
      tick();
      rst = 1'b0; resume = 1'b0;
      checks++; if (pc !== 32'h0 || flush !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL abort_halt got pc %h flush %b halted %b exp 0 0 0", pc, flush, halted); end
      checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL abort_plus4 got %h exp %h", pc_plus4, 32'h4); end
   endtask

   initial begin
      rst = 1'b1; branch = 2'b10; stall = 1'b0; resume = 1'b0;
      target_br = '0; target_jalr = '0;
      tick();
      test_reset();
      test_sequential();
      test_branch();
      test_jalr();
      test_halt();
      test_stall();
      test_wrap();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
